// File: rtl/alu_accum_seq_if.sv
// Command/result bundle between the operand front end and the accumulator ALU.
interface alu_accum_seq_if #(parameter int WIDTH = 8);
    logic             on;
    logic             start;
    logic [2:0]       in_sel;
    logic [6:0]       out_sel;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] final1;
    logic [WIDTH-1:0] final2;
    logic             ovf;
    logic             err;
    logic [1:0]       curr_state;

    modport master (
        output on, start, in_sel, out_sel, num1, num2,
        input  ready, done, out, final1, final2, ovf, err, curr_state
    );

    modport slave (
        input  on, start, in_sel, out_sel, num1, num2,
        output ready, done, out, final1, final2, ovf, err, curr_state
    );
endinterface

// File: rtl/alu_accum_seq.sv
// Handshaked accumulator ALU: seven one-hot ops on (loaded or persisted A, B),
// single-cycle logic/add/sub and an iterative WIDTH-cycle shift-add multiply.
module alu_accum_seq #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    alu_accum_seq_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc, a_q, b_q;
    logic               ovf_q, err_q;
    logic [5:0]         op_q;
    logic               is_mul, is_clr, is_bad;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod, prod_nxt;

    logic accept, clr_cmd, cmd_bad, last_iter, exec_fin;
    logic [WIDTH:0]     sum, dif;
    logic [WIDTH-1:0]   res;
    logic               res_ovf;

    assign accept    = bus.start & bus.ready;
    assign clr_cmd   = (bus.in_sel == 3'b100);
    // A clear command ignores the opcode entirely, so only its mode must be one-hot.
    assign cmd_bad   = !$onehot(bus.in_sel) | (!clr_cmd & !$onehot(bus.out_sel));
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign exec_fin  = !is_mul | last_iter;

    assign prod_nxt = prod + (b_q[cnt] ? ({{WIDTH{1'b0}}, a_q} << cnt) : '0);

    assign sum = {1'b0, a_q} + {1'b0, b_q};
    assign dif = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        if (op_q[5]) begin
            res     = dif[WIDTH-1:0];
            res_ovf = dif[WIDTH];
        end else if (op_q[4]) begin
            res     = sum[WIDTH-1:0];
            res_ovf = sum[WIDTH];
        end else if (op_q[3]) res = ~a_q;
        else if (op_q[2])     res = a_q ^ b_q;
        else if (op_q[1])     res = a_q | b_q;
        else if (op_q[0])     res = a_q & b_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (exec_fin) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            op_q   <= '0;
            is_mul <= 1'b0;
            is_clr <= 1'b0;
            is_bad <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
        end else if (accept) begin
            op_q   <= bus.out_sel[5:0];
            is_mul <= !cmd_bad & !clr_cmd & bus.out_sel[6];
            is_clr <= clr_cmd;
            is_bad <= cmd_bad;
            cnt    <= '0;
            prod   <= '0;
            // Illegal commands leave the operand snapshot untouched.
            if (!cmd_bad) begin
                if (clr_cmd) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= bus.in_sel[1] ? bus.num1 : acc;
                    b_q <= bus.num2;
                end
            end
        end else if (state == EXEC) begin
            if (is_mul) begin
                prod <= prod_nxt;
                cnt  <= cnt + 1'b1;
                if (last_iter) begin
                    acc   <= prod_nxt[WIDTH-1:0];
                    ovf_q <= |prod_nxt[2*WIDTH-1:WIDTH];
                    err_q <= 1'b0;
                end
            end else if (is_bad) begin
                err_q <= 1'b1;
            end else if (is_clr) begin
                acc   <= '0;
                ovf_q <= 1'b0;
                err_q <= 1'b0;
            end else begin
                acc   <= res;
                ovf_q <= res_ovf;
                err_q <= 1'b0;
            end
        end
    end

    assign bus.ready      = (state == IDLE) & bus.on;
    assign bus.done       = (state == DONE);
    assign bus.out        = acc;
    assign bus.final1     = a_q;
    assign bus.final2     = b_q;
    assign bus.ovf        = ovf_q;
    assign bus.err        = err_q;
    assign bus.curr_state = state;
endmodule

// File: doc/alu_accum_seq.md
# alu_accum_seq

Parametrised, handshaked successor to the 8-bit accumulator ALU. It executes one of seven one-hot-selected operations (MUL, SUB, ADD, NOT, XOR, OR, AND) on an operand pair. The A operand is either freshly loaded or taken from the persisted previous result. MUL uses an iterative shift-add engine over WIDTH cycles. The block sits between the operand/command front end and the result display/bench logic, and exposes the operands actually used, overflow and error flags, and its FSM state.

## Interface

**Parameters**
- WIDTH, 8: operand, accumulator and result width in bits; must be ≥ 2.

**Ports**
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- on  in  1  enable. Gates command acceptance only.
- start  in  1  command request.
- in_sel  in  3  one-hot command mode: bit2 = reset accumulator, bit1 = load (A = num1), bit0 = persist (A = out).
- out_sel  in  7  one-hot operation: bit6 MUL, bit5 SUB, bit4 ADD, bit3 NOT, bit2 XOR, bit1 OR, bit0 AND.
- num1  in  WIDTH  A operand, used when loading.
- num2  in  WIDTH  B operand.
- ready  out  1  = (curr_state == IDLE) & on. Combinational.
- done  out  1  one-cycle completion pulse.
- out  out  WIDTH  accumulator / result register.
- final1, final2  out  WIDTH  A and B operands latched at acceptance.
- ovf  out  1  carry / borrow / multiply overflow of the last operation.
- err  out  1  the last accepted command had a non-one-hot in_sel or out_sel.
- curr_state  out  2  IDLE = 00, EXEC = 01, DONE = 10. Code 11 is unreachable and recovers to IDLE.

## Operation

**Acceptance**
- A command is accepted on a rising edge where start & ready.
- At acceptance the block latches:
  - final1 = num1 (load) or out (persist),
  - final2 = num2,
  - the opcode and the mode.
- Inputs are don't-care after acceptance.

**Operations** (A = final1, B = final2, all results taken mod 2^WIDTH)
- ADD: A + B. ovf = carry out.
- SUB: A − B. ovf = borrow (A < B, unsigned).
- MUL: unsigned A × B. out = low WIDTH bits. ovf = 1 if any bit of the upper WIDTH bits of the 2·WIDTH product is set.
- NOT: ~A, with B ignored. ovf = 0.
- XOR, OR, AND: bitwise. ovf = 0.

**Reset command** (in_sel = 100)
- Clears out, final1, final2 and ovf. out_sel is ignored.

**Illegal command** (in_sel or out_sel not one-hot, including all-zero)
- out, final1, final2 and ovf are unchanged; err = 1.
- err clears on the next accepted legal command.

**FSM**
- IDLE → EXEC on acceptance.
- EXEC lasts 1 cycle for all non-MUL commands (reset and illegal commands included).
- EXEC lasts WIDTH cycles for MUL. A log2(WIDTH)-bit iteration counter drives a one-bit-per-cycle shift-add into a 2·WIDTH partial product.
- EXEC → DONE when the result is written to out.
- DONE → IDLE unconditionally after one cycle. done = 1 only while in DONE.
- ready is 0 in EXEC and DONE.

**Boundary conditions**
- on falling during EXEC or DONE: the operation completes normally. on = 0 only blocks new acceptance.
- start held high through completion: a new command is accepted on the first edge back in IDLE.
- Persist with MUL: A is the snapshot of out taken at acceptance.
- rst asserted at any time: immediately forces IDLE and zeroes out, final1, final2, ovf, err, done and the counter. An in-flight operation is aborted with no done pulse.

## Timing

- Reset values: curr_state = 00; out, final1, final2 = 0; ovf = err = done = 0. ready follows on.
- Acceptance at edge k, non-MUL: out, ovf and err are valid after edge k+1; done is high from k+1 to k+2; ready returns after k+2. Minimum command spacing is 3 cycles.
- Acceptance at edge k, MUL: out is valid after edge k+WIDTH; done is high from k+WIDTH to k+WIDTH+1; spacing is WIDTH+2 cycles.
- final1 and final2 are valid from edge k onward.
- out changes only on the EXEC→DONE edge, or on rst.

## Test plan

- WIDTH = 8, load MUL 3 × 2 → curr_state EXEC for 8 cycles; out = 6, ovf = 0; done one cycle at k+8.
- Load MUL 87 × 26 (product 2262) → out = 0xD6 (214), ovf = 1.
- Load SUB 2 − 4 → out = 0xFE, ovf = 1. Then persist ADD with num2 = 3 → final1 = 0xFE, out = 0x01, ovf = 1.
- Logic ops, load 50/25:
  - XOR → 43, OR → 59, AND → 16, each ovf = 0.
  - NOT, load 129 → 126.
- Control cases:
  - Reset command (in_sel = 100) → out = 0.
  - in_sel = 011 → err = 1, out unchanged.
  - rst low at cycle 4 of a MUL → immediate IDLE, all outputs 0, no done pulse.
- Enable and width cases:
  - on = 0 with start held → ready = 0, state stays IDLE.
  - WIDTH = 16, load MUL 300 × 300 → out = 24464, ovf = 1, done at k+16.
